// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter and the
// downstream Excess-3 stages.
package bcd_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One packed BCD digit; also used by the Excess-3 encoder.
    typedef logic [3:0] bcd_digit_t;

    // A digit at or above this value gets +3 before the next shift.
    localparam bcd_digit_t ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready stream bundle between the upstream producer, the converter and
// the Excess-3 consumer.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    // Producer/consumer side (drives operands, accepts results).
    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, overflow
    );

    // Converter side.
    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, overflow
    );
endinterface

// File: rtl/dabble_digit.sv
// One double-dabble correction cell: a digit of 5 or more is bumped by 3 so
// the following left shift carries correctly into the next decimal digit.
module dabble_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);
    // 4-bit add, any carry out is intentionally dropped.
    assign o_digit = (i_digit >= ADD3_THRESH) ? bcd_digit_t'(i_digit + 4'd3) : i_digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One word is taken
// over the input handshake, shifted BIN_W times, and the packed BCD result is
// held in a register until the next conversion finishes.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    bin_to_bcd_seq_if.slave bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SR_W-1:0]    r_shift;      // {bcd field, remaining binary bits}
    logic               r_ovf_work;   // sticky overflow of the running conversion
    logic [BCD_W-1:0]   r_bcd_out;
    logic               r_overflow;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [SR_W-1:0]    w_adj;
    logic [SR_W-1:0]    w_shifted;
    logic               w_msb_out;

    // Add-3 correction on every digit of the BCD field.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            dabble_digit u_digit (
                .i_digit (r_shift[BIN_W + 4*gi +: 4]),
                .o_digit (w_bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    assign w_adj     = {w_bcd_adj, r_shift[BIN_W-1:0]};
    // A bit leaving the top digit means the value does not fit in DIGITS digits.
    assign w_msb_out = w_adj[SR_W-1];
    assign w_shifted = {w_adj[SR_W-2:0], 1'b0};

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.bcd_out   = r_bcd_out;
    assign bus.overflow  = r_overflow;

    // Control FSM with registered handshake outputs and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_ovf_work  <= 1'b0;
            r_bcd_out   <= '0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_shift    <= {{BCD_W{1'b0}}, bus.bin_in};
                        r_ovf_work <= 1'b0;
                        r_cnt      <= CNT_LOAD;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift <= w_shifted;
                    r_cnt   <= r_cnt - CNT_LAST;
                    if (w_msb_out) begin
                        r_ovf_work <= 1'b1;
                    end
                    if (r_cnt == CNT_LAST) begin
                        // Result registers change only here, on DONE entry.
                        r_bcd_out   <= w_shifted[SR_W-1 -: BCD_W];
                        r_overflow  <= r_ovf_work | w_msb_out;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
